// File: rtl/la_csa_accum_if.sv
// Stream bundle for la_csa_accum: operand beats in, resolved sum/count out.
// The master modport drives operands and takes results; slave is the accumulator side.
interface la_csa_accum_if #(
    parameter int unsigned W    = 16,
    parameter int unsigned AW   = 24,
    parameter int unsigned CNTW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_bvalid;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_data;
    logic [CNTW-1:0] out_cnt;

    modport master (
        output in_valid, in_a, in_b, in_bvalid, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_bvalid, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/la_csa_accum.sv
// Multi-operand accumulator: each beat folds up to two operands into a redundant S/C
// state via a row of 4:2 compressors, then resolves it CW bits per cycle on the last beat.
module la_csa_accum #(
    parameter int unsigned W    = 16,
    parameter int unsigned AW   = 24,
    parameter int unsigned CW   = 8,
    parameter int unsigned CNTW = 8
) (
    input logic           clk,
    input logic           reset,
    la_csa_accum_if.slave io_bus
);
    localparam int unsigned NCH = AW / CW;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StAcc, StRes, StOut} state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic [AW-1:0]   r_s;
    logic [AW-1:0]   r_c;
    logic [AW-1:0]   r_res;
    logic [CNTW-1:0] r_cnt;
    logic [IW-1:0]   r_idx;
    logic            r_rc;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_last_chunk;
    logic [AW-1:0]   w_opa;
    logic [AW-1:0]   w_opb;
    logic [AW-1:0]   w_cb;
    logic [AW-1:0]   w_s1;
    logic [AW-1:0]   w_co;
    logic [AW-1:0]   w_cin;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_car;
    logic [CW:0]     w_chunk;
    logic [CNTW:0]   w_cnt_inc;
    logic [CNTW-1:0] w_cnt_nxt;

    assign io_bus.in_ready  = (r_state == StAcc);
    assign io_bus.out_valid = (r_state == StOut);
    assign io_bus.out_data  = r_res;
    assign io_bus.out_cnt   = r_cnt;

    assign w_in_fire    = io_bus.in_valid & (r_state == StAcc);
    assign w_out_fire   = io_bus.out_ready & (r_state == StOut);
    assign w_last_chunk = (r_idx == IW'(NCH - 1));

    assign w_opa = AW'(io_bus.in_a);
    assign w_opb = io_bus.in_bvalid ? AW'(io_bus.in_b) : '0;
    assign w_cb  = {r_c[AW-2:0], 1'b0};

    // 4:2 row: the inter-column carry (w_co) never depends on w_cin, so nothing ripples.
    assign w_s1  = r_s ^ w_cb ^ w_opa;
    assign w_co  = (r_s & w_cb) | (r_s & w_opa) | (w_cb & w_opa);
    assign w_cin = {w_co[AW-2:0], 1'b0};
    assign w_sum = w_s1 ^ w_opb ^ w_cin;
    assign w_car = (w_s1 & w_opb) | (w_s1 & w_cin) | (w_opb & w_cin);

    assign w_cnt_inc = {1'b0, r_cnt} + (CNTW+1)'(1) + (CNTW+1)'(io_bus.in_bvalid);
    assign w_cnt_nxt = w_cnt_inc[CNTW] ? '1 : w_cnt_inc[CNTW-1:0];

    assign w_chunk = {1'b0, r_s[r_idx*CW +: CW]} + {1'b0, w_cb[r_idx*CW +: CW]}
                   + (CW+1)'(r_rc);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StAcc:   if (w_in_fire && io_bus.in_last) w_state_nxt = StRes;
            StRes:   if (w_last_chunk) w_state_nxt = StOut;
            StOut:   if (w_out_fire) w_state_nxt = StAcc;
            default: w_state_nxt = StAcc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StAcc;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s   <= '0;
            r_c   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_rc  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s   <= w_sum;
                r_c   <= w_car;
                r_cnt <= w_cnt_nxt;
                if (io_bus.in_last) begin
                    r_idx <= '0;
                    r_rc  <= 1'b0;
                end
            end
            if (r_state == StRes) begin
                r_res[r_idx*CW +: CW] <= w_chunk[CW-1:0];
                r_rc                  <= w_chunk[CW];
                r_idx                 <= r_idx + IW'(1);
            end
            // Result register is left alone so out_data holds until the next resolve.
            if (w_out_fire) begin
                r_s   <= '0;
                r_c   <= '0;
                r_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_la_csa_accum.sv
// Directed bench for la_csa_accum (W=16, AW=24, CW=8): hand-computed packet sums,
// latency, backpressure hold, mid-resolve reset, and a few model-checked packets.
module tb_la_csa_accum;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   lat;
    logic [23:0] msum;
    logic [8:0]  mcnt;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vbv;

    la_csa_accum_if #(.W(16), .AW(24), .CNTW(8)) bus ();

    la_csa_accum #(.W(16), .AW(24), .CW(8), .CNTW(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic bv,
                             input logic last);
        int t;
        t = 0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_bvalid = bv;
        bus.in_last   = last;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_bvalid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [23:0] ed, input logic [7:0] ec,
                              input int stall, output int latency);
        int t;
        t = 0;
        while (!bus.out_valid && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        latency = t;
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, "_hold_data"}, {8'd0, bus.out_data}, {8'd0, ed});
            chk({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        chk({tag, "_data"}, {8'd0, bus.out_data}, {8'd0, ed});
        chk({tag, "_cnt"}, {24'd0, bus.out_cnt}, {24'd0, ec});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
        chk({tag, "_data_kept"}, {8'd0, bus.out_data}, {8'd0, ed});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bvalid = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_data", {8'd0, bus.out_data}, 32'd0);
        chk("rst_out_cnt", {24'd0, bus.out_cnt}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single beat, both operands, plus latency.
        send_beat(16'd5, 16'd7, 1'b1, 1'b1);
        get_result("t1", 24'd12, 8'd2, 0, lat);
        chk("t1_latency", lat, 32'd3);

        // Carries crossing both chunk boundaries.
        send_beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send_beat(16'hFFFF, 16'h1234, 1'b0, 1'b0);
        send_beat(16'h0001, 16'h0001, 1'b1, 1'b1);
        get_result("t2", 24'h02FFFF, 8'd5, 0, lat);

        // 258 operands of FFFF: wraps mod 2^24, count saturates.
        for (int i = 0; i < 129; i++) begin
            send_beat(16'hFFFF, 16'hFFFF, 1'b1, (i == 128));
        end
        get_result("t3", 24'h01FEFE, 8'd255, 0, lat);

        // Backpressure: stray in_valid during RES/OUT must not be consumed.
        send_beat(16'h1234, 16'hAAAA, 1'b0, 1'b1);
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'h7777;
        bus.in_b      = 16'h5555;
        bus.in_bvalid = 1'b1;
        bus.in_last   = 1'b0;
        get_result("t4", 24'h001234, 8'd1, 10, lat);
        bus.in_bvalid = 1'b0;
        send_beat(16'd3, 16'd0, 1'b0, 1'b1);
        get_result("t4b", 24'd3, 8'd1, 0, lat);

        // Reset while chunk 1 of the resolve is pending.
        send_beat(16'h1111, 16'h2222, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t5_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("t5_rst_out_cnt", {24'd0, bus.out_cnt}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t5_no_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        send_beat(16'd9, 16'd0, 1'b0, 1'b1);
        get_result("t5b", 24'd9, 8'd1, 0, lat);

        // Multi-beat packets with mixed bvalid and output stalls against a plain sum.
        for (int p = 0; p < 4; p++) begin
            msum = '0;
            mcnt = '0;
            for (int i = 0; i < 1 + p * 13; i++) begin
                va   = 16'(p * 40503 + i * 9973);
                vb   = 16'(i * 31337 + p * 7 + 1);
                vbv  = ((i + p) % 3) != 0;
                msum = msum + 24'(va) + (vbv ? 24'(vb) : 24'd0);
                mcnt = mcnt + 9'd1 + 9'(vbv);
                if (mcnt > 9'd255) mcnt = 9'd255;
                send_beat(va, vb, vbv, (i == p * 13));
            end
            get_result("t6", msum, mcnt[7:0], p * 2, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
